// File: rtl/cell_comm_sync_pkg.sv
// Shared definitions for the synchronized-word qualifier.
//   state_t       : qualifier state, SETTLE while the word is still moving, STABLE once settled
//   OVERRUN_WIDTH : width of the saturating overrun counter
//   clog2         : ceiling log2, used to size counters from their limits
package cell_comm_sync_pkg;

   typedef enum logic [0:0] {
      SETTLE = 1'b0,
      STABLE = 1'b1
   } state_t;

   localparam int unsigned OVERRUN_WIDTH = 8;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr        : synchronous clear, has priority over inc
//   inc        : increment by one unless already at LIMIT
//   count      : current value
module sat_counter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LIMIT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] MaxCount = WIDTH'(LIMIT);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q < MaxCount)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/sync_word_qualifier.sv
// Waits until a per-bit synchronized word has been unchanged for STABLE_CYCLES cycles, then
// publishes it once over a valid/ready handshake.
//   clk, rst_n   : clock, asynchronous active-low reset
//   dataIn       : synchronized word, current cycle
//   dataIn_pp    : synchronized word, previous cycle
//   dataOut      : last published coherent word
//   dataValid    : published word pending, held until accepted
//   dataReady    : consumer accepts dataOut when dataValid && dataReady
//   stable       : input currently settled (registered STABLE state)
//   overrunCount : undelivered words overwritten by a newer publish, saturating at 255
module sync_word_qualifier
   import cell_comm_sync_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_WIDTH-1:0]    dataIn,
   input  logic [DATA_WIDTH-1:0]    dataIn_pp,
   output logic [DATA_WIDTH-1:0]    dataOut,
   output logic                     dataValid,
   input  logic                     dataReady,
   output logic                     stable,
   output logic [OVERRUN_WIDTH-1:0] overrunCount
);

   localparam int unsigned CNT_WIDTH = clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(STABLE_CYCLES - 1);
   localparam int unsigned OverrunMax = (1 << OVERRUN_WIDTH) - 1;

   logic                  change;
   logic [CNT_WIDTH-1:0]  cnt;
   state_t                state;
   logic                  first_pending;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q;
   logic                  settling_done;
   logic                  publish;
   logic                  accept;
   logic                  overrun;

   assign change = (dataIn != dataIn_pp);

   sat_counter #(
      .WIDTH (CNT_WIDTH),
      .LIMIT (STABLE_CYCLES)
   ) u_stable_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (change),
      .inc   (1'b1),
      .count (cnt)
   );

   // The edge on which cnt reaches STABLE_CYCLES, i.e. the SETTLE->STABLE transition.
   assign settling_done = (state == SETTLE) && !change && (cnt == CntLast);
   // A word that settles back to what was already published is not sent again, except the
   // very first word after reset, which must go out even if it matches the reset value.
   assign publish = settling_done && (first_pending || (dataIn != data_q));
   assign accept  = valid_q && dataReady;
   // Publishing over a pending word that is accepted on the same edge is not a loss.
   assign overrun = publish && valid_q && !dataReady;

   sat_counter #(
      .WIDTH (OVERRUN_WIDTH),
      .LIMIT (OverrunMax)
   ) u_overrun_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .inc   (overrun),
      .count (overrunCount)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= SETTLE;
         first_pending <= 1'b1;
         data_q        <= '0;
         valid_q       <= 1'b0;
      end else begin
         unique case (state)
            SETTLE: if (settling_done) state <= STABLE;
            STABLE: if (change) state <= SETTLE;
         endcase

         if (publish) begin
            data_q        <= dataIn;
            valid_q       <= 1'b1;
            first_pending <= 1'b0;
         end else if (accept) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign dataOut   = data_q;
   assign dataValid = valid_q;
   assign stable    = (state == STABLE);

endmodule

// File: tb/tb_sync_word_qualifier.sv
// Self-checking bench for sync_word_qualifier (DATA_WIDTH=8, STABLE_CYCLES=4).
// A directed vector table covers the main flows; hand sequences cover asynchronous reset and
// overrun saturation; a random phase is checked against a behavioural model.
module tb_sync_word_qualifier;

   localparam int SC = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] dataIn;
   logic [7:0] dataIn_pp;
   logic [7:0] dataOut;
   logic       dataValid;
   logic       dataReady;
   logic       stable;
   logic [7:0] overrunCount;

   always #5 clk = ~clk;

   sync_word_qualifier #(
      .DATA_WIDTH    (8),
      .STABLE_CYCLES (SC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dataIn       (dataIn),
      .dataIn_pp    (dataIn_pp),
      .dataOut      (dataOut),
      .dataValid    (dataValid),
      .dataReady    (dataReady),
      .stable       (stable),
      .overrunCount (overrunCount)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model: run = consecutive quiet cycles since the last change or reset.
   int         run;
   logic [7:0] m_out;
   bit         m_valid;
   bit         m_first;
   int         m_ovr;

   typedef struct {
      logic [7:0] din;
      bit         rdy;
      logic [7:0] out;
      bit         valid;
      bit         stab;
      logic [7:0] ovr;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      run     = 0;
      m_out   = 8'h00;
      m_valid = 1'b0;
      m_first = 1'b1;
      m_ovr   = 0;
   endtask

   task automatic model_step(input logic [7:0] din, input logic [7:0] pp, input bit rdy);
      bit publish;
      if (din != pp) run = 0;
      else run = run + 1;
      // Publish exactly once, when the quiet run first reaches SC cycles.
      publish = (run == SC) && ((din != m_out) || m_first);
      if (publish) begin
         if (m_valid && !rdy && m_ovr < 255) m_ovr = m_ovr + 1;
         m_out   = din;
         m_valid = 1'b1;
         m_first = 1'b0;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic check_model();
      chk("model_dataOut", 32'(dataOut), 32'(m_out));
      chk("model_dataValid", 32'(dataValid), 32'(m_valid));
      chk("model_stable", 32'(stable), 32'(run >= SC));
      chk("model_overrunCount", 32'(overrunCount), 32'(m_ovr));
   endtask

   // One clock cycle: drive inputs, let the edge happen, check, then shift the delayed copy.
   task automatic step(input logic [7:0] din, input bit rdy);
      dataIn    = din;
      dataReady = rdy;
      model_step(din, dataIn_pp, rdy);
      @(posedge clk);
      #1;
      dataIn_pp = din;
      check_model();
   endtask

   task automatic add(input logic [7:0] din, input bit rdy, input logic [7:0] out,
                      input bit valid, input bit stab, input logic [7:0] ovr);
      vec_t v;
      v.din = din; v.rdy = rdy; v.out = out; v.valid = valid; v.stab = stab; v.ovr = ovr;
      tbl.push_back(v);
   endtask

   task automatic add_n(input int n, input logic [7:0] din, input bit rdy, input logic [7:0] out,
                        input bit valid, input bit stab, input logic [7:0] ovr);
      for (int i = 0; i < n; i++) add(din, rdy, out, valid, stab, ovr);
   endtask

   initial begin
      logic [7:0] w;
      logic [7:0] d;

      // Steady zero from reset, first publish after 4 quiet cycles.
      add_n(3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0);
      add  (   8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'd0);
      // 0x00 -> 0xA5 with ready: old word accepted, new one 5 cycles after the change.
      add_n(4, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0);
      add  (   8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1, 8'd0);
      add  (   8'hA5, 1'b1, 8'hA5, 1'b0, 1'b1, 8'd0);
      add  (   8'hA5, 1'b0, 8'hA5, 1'b0, 1'b1, 8'd0);
      // One-cycle glitch to 0x5A: stable drops, re-rises, no republish.
      add  (   8'h5A, 1'b0, 8'hA5, 1'b0, 1'b0, 8'd0);
      add_n(4, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 8'd0);
      add  (   8'hA5, 1'b0, 8'hA5, 1'b0, 1'b1, 8'd0);
      // 0x11 then 0x22 settle without ready: one overrun.
      add_n(4, 8'h11, 1'b0, 8'hA5, 1'b0, 1'b0, 8'd0);
      add  (   8'h11, 1'b0, 8'h11, 1'b1, 1'b1, 8'd0);
      add_n(4, 8'h22, 1'b0, 8'h11, 1'b1, 1'b0, 8'd0);
      add  (   8'h22, 1'b0, 8'h22, 1'b1, 1'b1, 8'd1);
      add  (   8'h22, 1'b1, 8'h22, 1'b0, 1'b1, 8'd1);
      // Publish of 0x44 coinciding with acceptance of 0x33: no overrun, valid stays 1.
      add_n(4, 8'h33, 1'b0, 8'h22, 1'b0, 1'b0, 8'd1);
      add  (   8'h33, 1'b0, 8'h33, 1'b1, 1'b1, 8'd1);
      add_n(4, 8'h44, 1'b0, 8'h33, 1'b1, 1'b0, 8'd1);
      add  (   8'h44, 1'b1, 8'h44, 1'b1, 1'b1, 8'd1);
      add  (   8'h44, 1'b1, 8'h44, 1'b0, 1'b1, 8'd1);

      rst_n     = 1'b0;
      dataIn    = 8'h00;
      dataIn_pp = 8'h00;
      dataReady = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_dataOut", 32'(dataOut), 32'h0);
      chk("reset_dataValid", 32'(dataValid), 32'h0);
      chk("reset_stable", 32'(stable), 32'h0);
      chk("reset_overrunCount", 32'(overrunCount), 32'h0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].din, tbl[i].rdy);
         chk("vec_dataOut", 32'(dataOut), 32'(tbl[i].out));
         chk("vec_dataValid", 32'(dataValid), 32'(tbl[i].valid));
         chk("vec_stable", 32'(stable), 32'(tbl[i].stab));
         chk("vec_overrunCount", 32'(overrunCount), 32'(tbl[i].ovr));
      end

      // Reset while 0x55 is pending and the next word has cnt=2.
      repeat (5) step(8'h55, 1'b0);
      step(8'h66, 1'b0);
      repeat (2) step(8'h66, 1'b0);
      chk("pre_reset_dataValid", 32'(dataValid), 32'h1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_reset_dataOut", 32'(dataOut), 32'h0);
      chk("async_reset_dataValid", 32'(dataValid), 32'h0);
      chk("async_reset_stable", 32'(stable), 32'h0);
      chk("async_reset_overrunCount", 32'(overrunCount), 32'h0);
      @(posedge clk);
      #1;
      dataIn    = 8'h55;
      dataIn_pp = 8'h55;
      rst_n     = 1'b1;
      repeat (3) step(8'h55, 1'b0);
      chk("post_reset_early_dataValid", 32'(dataValid), 32'h0);
      step(8'h55, 1'b0);
      chk("post_reset_repub_dataOut", 32'(dataOut), 32'h55);
      chk("post_reset_repub_dataValid", 32'(dataValid), 32'h1);

      // 300 overwrites with ready held low: counter saturates.
      for (int i = 0; i < 300; i++) begin
         w = (i % 2 == 0) ? 8'h3C : 8'hC3;
         repeat (SC + 1) step(w, 1'b0);
      end
      chk("overrun_saturated", 32'(overrunCount), 32'd255);
      chk("overrun_last_word", 32'(dataOut), 32'hC3);

      // Fresh reset, then random traffic against the model.
      #2;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      dataIn    = 8'h00;
      dataIn_pp = 8'h00;
      rst_n     = 1'b1;
      d = 8'h00;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) d = 8'($urandom_range(0, 3));
         step(d, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
